// File: rtl/pipeline_pack_if.sv
// Handshake bundle for pipeline_pack: narrow beats in from upstream, packed words out downstream.
interface pipeline_pack_if #(
  parameter int VALUE_BITS = 8,
  parameter int PACK_COUNT = 4
);
  localparam int COUNT_BITS = $clog2(PACK_COUNT + 1);

  logic [VALUE_BITS-1:0]            i_value;
  logic                             i_last;
  logic                             i_valid;
  logic                             o_ready;
  logic [VALUE_BITS*PACK_COUNT-1:0] o_value;
  logic [COUNT_BITS-1:0]            o_count;
  logic                             o_last;
  logic                             o_valid;
  logic                             i_ready;

  modport master (
    output i_value, i_last, i_valid, i_ready,
    input  o_ready, o_value, o_count, o_last, o_valid
  );

  modport slave (
    input  i_value, i_last, i_valid, i_ready,
    output o_ready, o_value, o_count, o_last, o_valid
  );
endinterface

// File: rtl/pipeline_pack.sv
// Packs VALUE_BITS beats into PACK_COUNT-lane words; a word closes when full or on i_last.
module pipeline_pack #(
  parameter int VALUE_BITS = 8,
  parameter int PACK_COUNT = 4
) (
  input  logic            clock,
  input  logic            reset,
  pipeline_pack_if.slave  bus
);
  localparam int COUNT_BITS = $clog2(PACK_COUNT + 1);
  localparam int WORD_BITS  = VALUE_BITS * PACK_COUNT;

  logic [WORD_BITS-1:0]  pack_r;
  logic [COUNT_BITS-1:0] count_r;
  logic [WORD_BITS-1:0]  word_r;
  logic [COUNT_BITS-1:0] word_count_r;
  logic                  word_last_r;
  logic                  word_valid_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  complete_s;
  logic                  drain_s;
  logic [WORD_BITS-1:0]  merged_s;

  // Handshake qualifiers; the output stage frees itself whenever downstream takes the word.
  always_comb begin
    ready_s    = ~word_valid_r | bus.i_ready;
    accept_s   = bus.i_valid & ready_s;
    drain_s    = word_valid_r & bus.i_ready;
    complete_s = accept_s & ((count_r == COUNT_BITS'(PACK_COUNT - 1)) | bus.i_last);
  end

  // Accumulator with the incoming beat dropped into lane count_r and every higher lane zeroed.
  always_comb begin
    merged_s = pack_r;
    for (int k = 0; k < PACK_COUNT; k++) begin
      if (COUNT_BITS'(k) == count_r) begin
        merged_s[k*VALUE_BITS +: VALUE_BITS] = bus.i_value;
      end else if (COUNT_BITS'(k) > count_r) begin
        merged_s[k*VALUE_BITS +: VALUE_BITS] = {VALUE_BITS{1'b0}};
      end else begin
        merged_s[k*VALUE_BITS +: VALUE_BITS] = pack_r[k*VALUE_BITS +: VALUE_BITS];
      end
    end
  end

  // Accumulator, lane counter and the registered output word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pack_r       <= {WORD_BITS{1'b0}};
      count_r      <= {COUNT_BITS{1'b0}};
      word_r       <= {WORD_BITS{1'b0}};
      word_count_r <= {COUNT_BITS{1'b0}};
      word_last_r  <= 1'b0;
      word_valid_r <= 1'b0;
    end else if (complete_s) begin
      // A completing beat reloads the output even while the old word drains: no bubble.
      word_r       <= merged_s;
      word_count_r <= count_r + COUNT_BITS'(1);
      word_last_r  <= bus.i_last;
      word_valid_r <= 1'b1;
      pack_r       <= {WORD_BITS{1'b0}};
      count_r      <= {COUNT_BITS{1'b0}};
    end else begin
      if (drain_s) begin
        word_valid_r <= 1'b0;
      end else begin
        word_valid_r <= word_valid_r;
      end
      if (accept_s) begin
        pack_r  <= merged_s;
        count_r <= count_r + COUNT_BITS'(1);
      end else begin
        pack_r  <= pack_r;
        count_r <= count_r;
      end
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_value = word_r;
  assign bus.o_count = word_count_r;
  assign bus.o_last  = word_last_r;
  assign bus.o_valid = word_valid_r;
endmodule
